fpu_addsub_ctrl: RTL and testbench

FPU_ADDSUB_CTRL -- requirements
Module: fpu_addsub_ctrl

---
 rtl/fpu_pkg.sv | 26 ++
 rtl/fpu_bypass_result.sv | 40 ++++
 rtl/fpu_addsub_ctrl.sv | 166 ++++++++++++++++
 tb/tb_fpu_addsub_ctrl.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared encodings for the FP add/sub controller: exception flags,
// special values and the controller state type.
package fpu_pkg;

    localparam logic [2:0] FLAG_NONE          = 3'b000;
    localparam logic [2:0] FLAG_NAN           = 3'b001;
    localparam logic [2:0] FLAG_COPY_A        = 3'b010;
    localparam logic [2:0] FLAG_COPY_B        = 3'b011;
    localparam logic [2:0] FLAG_FIN_MIN_INF   = 3'b100;
    localparam logic [2:0] FLAG_ZERO_MIN_ZERO = 3'b101;
    localparam logic [2:0] FLAG_ZERO_MIN_SOME = 3'b110;
    localparam logic [2:0] FLAG_SUB_SAME_VAL  = 3'b111;

    localparam logic [31:0] CAN_NAN = 32'h7FC0_0000;
    localparam logic [31:0] POS_INF = 32'h7F80_0000;
    localparam logic [31:0] NEG_INF = 32'hFF80_0000;

    typedef enum logic [2:0] {
        IDLE,
        CLASS,
        EXEC,
        BYPASS,
        RESP
    } state_t;

endpackage

// File: rtl/fpu_bypass_result.sv
// Forms the final result for operand pairs the exception block has
// already resolved, so the adder never has to run for them.
module fpu_bypass_result
    import fpu_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int EXP_BITS  = 8,
    parameter int MANT_BITS = 23
) (
    input  logic [WIDTH-1:0] a,
    input  logic             b_sign,
    input  logic             op,
    input  logic [2:0]       flag,
    input  logic [WIDTH-2:0] copied,
    output logic [WIDTH-1:0] result
);

    logic sb;
    logic a_inf;
    logic inf_sign;

    always_comb begin
        // b's effective sign once the subtraction has been folded in
        sb       = b_sign ^ op;
        a_inf    = (a[WIDTH-2 -: EXP_BITS] == {EXP_BITS{1'b1}}) &&
                   (a[MANT_BITS-1:0] == '0);
        inf_sign = a_inf ? a[WIDTH-1] : sb;
        result   = '0;
        case (flag)
            FLAG_NAN:           result = CAN_NAN;
            FLAG_COPY_A:        result = {a[WIDTH-1], copied};
            FLAG_COPY_B:        result = {sb, copied};
            FLAG_FIN_MIN_INF:   result = inf_sign ? NEG_INF : POS_INF;
            FLAG_ZERO_MIN_ZERO: result = {a[WIDTH-1] & sb, {(WIDTH-1){1'b0}}};
            FLAG_ZERO_MIN_SOME: result = {sb, copied};
            default:            result = '0;
        endcase
    end

endmodule

// File: rtl/fpu_addsub_ctrl.sv
// Sequencer for an FP add/sub: classifies operands through the exception
// block, then either bypasses the adder or runs it with a timeout.
module fpu_addsub_ctrl
    import fpu_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int EXP_BITS    = 8,
    parameter int MANT_BITS   = 23,
    parameter int ADD_TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic             req_op,
    output logic [WIDTH-1:0] exc_a,
    output logic [WIDTH-1:0] exc_b,
    output logic             exc_op,
    input  logic [2:0]       exc_flag,
    input  logic [WIDTH-2:0] exc_copied,
    output logic             add_start,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    output logic             add_op,
    input  logic             add_done,
    input  logic [WIDTH-1:0] add_result,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic [2:0]       rsp_flag,
    output logic             rsp_bypass,
    output logic             rsp_timeout,
    output logic             busy
);

    localparam int CW = $clog2(ADD_TIMEOUT + 1);
    localparam logic [CW-1:0] EXEC_LAST = CW'(ADD_TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    state_t           state;
    state_t           state_nxt;
    logic [1:0]       class_cnt;
    logic [CW-1:0]    exec_cnt;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             op_q;
    logic [2:0]       flag_q;
    logic [WIDTH-2:0] copied_q;
    logic [WIDTH-1:0] result_q;
    logic             bypass_q;
    logic             timeout_q;
    logic [WIDTH-1:0] bypass_result;
    logic             accept;
    logic             class_last;
    logic             exec_expire;

    fpu_bypass_result #(
        .WIDTH    (WIDTH),
        .EXP_BITS (EXP_BITS),
        .MANT_BITS(MANT_BITS)
    ) u_bypass (
        .a      (a_q),
        .b_sign (b_q[WIDTH-1]),
        .op     (op_q),
        .flag   (flag_q),
        .copied (copied_q),
        .result (bypass_result)
    );

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        accept      = (state == IDLE) && req_valid;
        class_last  = (class_cnt == 2'd1);
        exec_expire = (exec_cnt == EXEC_LAST) && !add_done;
        state_nxt   = state;
        case (state)
            IDLE:    if (req_valid) state_nxt = CLASS;
            CLASS:   if (class_last) state_nxt = (exc_flag == FLAG_NONE) ? EXEC : BYPASS;
            EXEC:    if (add_done || exec_expire) state_nxt = RESP;
            BYPASS:  state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_ready   = (state == IDLE);
        busy        = (state != IDLE);
        add_start   = (state == EXEC) && (exec_cnt == '0);
        rsp_valid   = (state == RESP);
        exc_a       = a_q;
        exc_b       = b_q;
        exc_op      = op_q;
        add_a       = a_q;
        add_b       = b_q;
        add_op      = op_q;
        rsp_result  = result_q;
        rsp_flag    = flag_q;
        rsp_bypass  = bypass_q;
        rsp_timeout = timeout_q;
    end

    // Operand latch, classification sample, adder capture and response hold.
    // Nothing changes in RESP, which keeps the response fields stable.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= 1'b0;
            flag_q    <= '0;
            copied_q  <= '0;
            result_q  <= '0;
            bypass_q  <= 1'b0;
            timeout_q <= 1'b0;
            class_cnt <= '0;
            exec_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_q       <= req_a;
                        b_q       <= req_b;
                        op_q      <= req_op;
                        flag_q    <= '0;
                        copied_q  <= '0;
                        result_q  <= '0;
                        bypass_q  <= 1'b0;
                        timeout_q <= 1'b0;
                        class_cnt <= '0;
                        exec_cnt  <= '0;
                    end
                end
                CLASS: begin
                    class_cnt <= class_cnt + 2'd1;
                    if (class_last) begin
                        flag_q   <= exc_flag;
                        copied_q <= exc_copied;
                        exec_cnt <= '0;
                    end
                end
                EXEC: begin
                    exec_cnt <= exec_cnt + CNT_ONE;
                    if (add_done) begin
                        result_q <= add_result;
                    end else if (exec_expire) begin
                        result_q  <= CAN_NAN;
                        timeout_q <= 1'b1;
                    end
                end
                BYPASS: begin
                    result_q <= bypass_result;
                    bypass_q <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_addsub_ctrl.sv
// Directed bench for fpu_addsub_ctrl: a request-level reference model
// checked every cycle, plus hand-computed expectations per scenario.
module tb_fpu_addsub_ctrl;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        arst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_a = '0;
    logic [31:0] req_b = '0;
    logic        req_op = 1'b0;
    logic [31:0] exc_a;
    logic [31:0] exc_b;
    logic        exc_op;
    logic [2:0]  exc_flag = '0;
    logic [30:0] exc_copied = '0;
    logic        add_start;
    logic [31:0] add_a;
    logic [31:0] add_b;
    logic        add_op;
    logic        add_done = 1'b0;
    logic [31:0] add_result = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_result;
    logic [2:0]  rsp_flag;
    logic        rsp_bypass;
    logic        rsp_timeout;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // adder model controls
    int          add_delay = -1;
    int          done_cycle = -1;
    logic [31:0] add_value = '0;
    int          start_count = 0;

    // reference model of the request currently in flight
    logic        m_busy = 1'b0;
    logic        m_classified = 1'b0;
    logic        m_exec = 1'b0;
    logic        m_resolved = 1'b0;
    int          m_tacc = 0;
    int          m_resp = 0;
    logic [31:0] m_a = '0;
    logic [31:0] m_b = '0;
    logic        m_op = 1'b0;
    logic [31:0] m_res = '0;
    logic [2:0]  m_flag = '0;
    logic        m_byp = 1'b0;
    logic        m_to = 1'b0;

    fpu_addsub_ctrl #(
        .WIDTH(32), .EXP_BITS(8), .MANT_BITS(23), .ADD_TIMEOUT(TO)
    ) dut (
        .clk(clk), .arst_n(arst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op),
        .exc_a(exc_a), .exc_b(exc_b), .exc_op(exc_op),
        .exc_flag(exc_flag), .exc_copied(exc_copied),
        .add_start(add_start), .add_a(add_a), .add_b(add_b), .add_op(add_op),
        .add_done(add_done), .add_result(add_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_flag(rsp_flag),
        .rsp_bypass(rsp_bypass), .rsp_timeout(rsp_timeout),
        .busy(busy)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc <= cyc + 1;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s at cycle %0d: got 0x%08h, expected 0x%08h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [31:0] expectBypass(input logic [31:0] a, input logic [31:0] b,
                                                 input logic op, input logic [2:0] flag,
                                                 input logic [30:0] copied);
        logic sb;
        logic s;
        sb = b[31] ^ op;
        case (flag)
            3'b001: return 32'h7FC0_0000;
            3'b010: return {a[31], copied};
            3'b011: return {sb, copied};
            3'b100: begin
                s = (a[30:23] == 8'hFF && a[22:0] == 23'd0) ? a[31] : sb;
                return {s, 8'hFF, 23'd0};
            end
            3'b101: return {a[31] & sb, 31'd0};
            3'b110: return {sb, copied};
            default: return 32'h0;
        endcase
    endfunction

    // Request-level model: accept, sample the flag two cycles later, then
    // either a one-cycle bypass or an adder wait bounded by TO cycles.
    initial forever begin
        @(posedge clk or negedge arst_n);
        if (!arst_n) begin
            m_busy = 1'b0; m_classified = 1'b0; m_resolved = 1'b0;
            m_a = '0; m_b = '0; m_op = 1'b0;
        end else if (m_busy && m_resolved && cyc >= m_resp && rsp_ready) begin
            m_busy = 1'b0;
        end else if (!m_busy && req_valid) begin
            m_busy = 1'b1; m_classified = 1'b0; m_resolved = 1'b0;
            m_tacc = cyc; m_a = req_a; m_b = req_b; m_op = req_op;
        end else if (m_busy && !m_resolved) begin
            if (cyc == m_tacc + 2) begin
                m_classified = 1'b1;
                m_flag = exc_flag;
                m_exec = (exc_flag == 3'b000);
                if (!m_exec) begin
                    m_res = expectBypass(m_a, m_b, m_op, exc_flag, exc_copied);
                    m_byp = 1'b1; m_to = 1'b0; m_resolved = 1'b1; m_resp = m_tacc + 4;
                end
            end else if (m_classified && m_exec && cyc >= m_tacc + 3) begin
                if (add_done) begin
                    m_res = add_result; m_byp = 1'b0; m_to = 1'b0;
                    m_resolved = 1'b1; m_resp = cyc + 1;
                end else if (cyc == m_tacc + 3 + TO - 1) begin
                    m_res = 32'h7FC0_0000; m_byp = 1'b0; m_to = 1'b1;
                    m_resolved = 1'b1; m_resp = cyc + 1;
                end
            end
        end
    end

    // Adder model: completes add_delay cycles after the start pulse.
    initial forever begin
        @(negedge clk);
        if (!arst_n) begin
            done_cycle = -1;
        end else if (add_start) begin
            start_count++;
            if (add_delay >= 0) done_cycle = cyc + add_delay;
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (arst_n && done_cycle == cyc) begin
            add_done = 1'b1; add_result = add_value;
        end else begin
            add_done = 1'b0; add_result = 32'hDEAD_BEEF;
        end
    end

    // Every-cycle comparison of the DUT against the model.
    initial forever begin
        @(negedge clk);
        begin
            logic ev;
            logic es;
            ev = m_busy && m_resolved && (cyc >= m_resp);
            es = m_busy && m_classified && m_exec && (cyc == m_tacc + 3);
            checkOutput("req_ready", 32'(req_ready), 32'(!m_busy));
            checkOutput("busy", 32'(busy), 32'(m_busy));
            checkOutput("add_start", 32'(add_start), 32'(es));
            checkOutput("rsp_valid", 32'(rsp_valid), 32'(ev));
            checkOutput("exc_a", exc_a, m_a);
            checkOutput("exc_b", exc_b, m_b);
            checkOutput("exc_op", 32'(exc_op), 32'(m_op));
            if (es) begin
                checkOutput("add_a", add_a, m_a);
                checkOutput("add_b", add_b, m_b);
                checkOutput("add_op", 32'(add_op), 32'(m_op));
            end
            if (ev) begin
                checkOutput("rsp_result", rsp_result, m_res);
                checkOutput("rsp_flag", 32'(rsp_flag), 32'(m_flag));
                checkOutput("rsp_bypass", 32'(rsp_bypass), 32'(m_byp));
                checkOutput("rsp_timeout", 32'(rsp_timeout), 32'(m_to));
            end
            if (!arst_n) begin
                checkOutput("rst_rsp_result", rsp_result, 32'h0);
                checkOutput("rst_rsp_flags", {29'd0, rsp_flag[0] | rsp_flag[1] | rsp_flag[2],
                                              rsp_bypass, rsp_timeout}, 32'h0);
                checkOutput("rst_add_a", add_a, 32'h0);
            end
        end
    end

    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic op,
                                 input logic [2:0] flag, input logic [30:0] copied,
                                 output int t);
        @(posedge clk); #1;
        req_a = a; req_b = b; req_op = op; req_valid = 1'b1; t = cyc;
        exc_flag = flag ^ 3'b111; exc_copied = ~copied;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        exc_flag = flag; exc_copied = copied;
        @(posedge clk); #1;
        exc_flag = flag ^ 3'b111; exc_copied = ~copied;
    endtask

    task automatic waitRsp(input int limit, output int at);
        at = -1;
        for (int i = 0; i < limit && at < 0; i++) begin
            @(negedge clk);
            if (rsp_valid) at = cyc;
        end
        if (at < 0) checkOutput("rsp_wait_expired", 32'h0, 32'h1);
    endtask

    task automatic runBypass(input string name, input logic [31:0] a, input logic [31:0] b,
                             input logic op, input logic [2:0] flag, input logic [30:0] copied,
                             input logic [31:0] exp);
        int t;
        int at;
        int s0;
        s0 = start_count;
        add_delay = -1;
        applyStimulus(a, b, op, flag, copied, t);
        waitRsp(20, at);
        checkOutput({name, "_latency"}, 32'(at - t), 32'd4);
        checkOutput({name, "_result"}, rsp_result, exp);
        checkOutput({name, "_bypass"}, 32'(rsp_bypass), 32'd1);
        checkOutput({name, "_flag"}, 32'(rsp_flag), 32'(flag));
        checkOutput({name, "_starts"}, 32'(start_count - s0), 32'd0);
    endtask

    task automatic runAdd(input string name, input logic [31:0] a, input logic [31:0] b,
                          input int delay, input logic [31:0] sum, input int lat);
        int t;
        int at;
        int s0;
        s0 = start_count;
        add_delay = delay; add_value = sum;
        applyStimulus(a, b, 1'b0, 3'b000, 31'h0, t);
        waitRsp(40, at);
        checkOutput({name, "_latency"}, 32'(at - t), 32'(lat));
        checkOutput({name, "_result"}, rsp_result, sum);
        checkOutput({name, "_bypass"}, 32'(rsp_bypass), 32'd0);
        checkOutput({name, "_timeout"}, 32'(rsp_timeout), 32'd0);
        checkOutput({name, "_starts"}, 32'(start_count - s0), 32'd1);
    endtask

    initial begin
        int t;
        int at;
        int s0;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_req_ready", 32'(req_ready), 32'd1);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("reset_add_start", 32'(add_start), 32'd0);
        @(posedge clk); #3;
        arst_n = 1'b1;

        runAdd("add", 32'h3F80_0000, 32'h4000_0000, 4, 32'h4040_0000, 8);
        runAdd("add_last_cycle", 32'h4000_0000, 32'h4100_0000, TO - 1, 32'h4120_0000, 19);

        runBypass("nan",        32'h7FC0_0001, 32'h3F80_0000, 1'b0, 3'b001, 31'h0,         32'h7FC0_0000);
        runBypass("copy_a",     32'h3F80_0000, 32'h8000_0000, 1'b1, 3'b010, 31'h3FC0_0000, 32'h3FC0_0000);
        runBypass("same_val",   32'h3F80_0000, 32'h8000_0000, 1'b1, 3'b111, 31'h1234_5678, 32'h0000_0000);
        runBypass("copy_b",     32'h3F80_0000, 32'h4000_0000, 1'b1, 3'b011, 31'h4000_0000, 32'hC000_0000);
        runBypass("inf_a_pos",  32'h7F80_0000, 32'h3F80_0000, 1'b1, 3'b100, 31'h0,         32'h7F80_0000);
        runBypass("inf_a_neg",  32'hFF80_0000, 32'h7F80_0000, 1'b0, 3'b100, 31'h0,         32'hFF80_0000);
        runBypass("inf_b",      32'h4000_0000, 32'h7F80_0000, 1'b1, 3'b100, 31'h0,         32'hFF80_0000);
        runBypass("zero_zero1", 32'h8000_0000, 32'h8000_0000, 1'b0, 3'b101, 31'h0,         32'h8000_0000);
        runBypass("zero_zero0", 32'h8000_0000, 32'h8000_0000, 1'b1, 3'b101, 31'h0,         32'h0000_0000);
        runBypass("zero_some",  32'h0000_0000, 32'h3F80_0000, 1'b1, 3'b110, 31'h3F80_0000, 32'hBF80_0000);

        // timeout with the late completion arriving while the response is held
        @(posedge clk); #1;
        rsp_ready = 1'b0; add_delay = 20; add_value = 32'h4120_0000;
        applyStimulus(32'h3F80_0000, 32'h3F80_0000, 1'b0, 3'b000, 31'h0, t);
        waitRsp(40, at);
        checkOutput("timeout_latency", 32'(at - t), 32'd19);
        checkOutput("timeout_result", rsp_result, 32'h7FC0_0000);
        checkOutput("timeout_flag", 32'(rsp_timeout), 32'd1);
        checkOutput("timeout_bypass", 32'(rsp_bypass), 32'd0);
        while (cyc < t + 24) @(negedge clk);
        checkOutput("late_done_valid", 32'(rsp_valid), 32'd1);
        checkOutput("late_done_result", rsp_result, 32'h7FC0_0000);
        checkOutput("late_done_timeout", 32'(rsp_timeout), 32'd1);
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        checkOutput("timeout_released", 32'(busy), 32'd0);

        // backpressure with a competing request held on req_valid
        rsp_ready = 1'b0; add_delay = -1;
        applyStimulus(32'h3F80_0000, 32'h4000_0000, 1'b1, 3'b011, 31'h4000_0000, t);
        waitRsp(20, at);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            req_valid = 1'b1; req_a = 32'h1234_5678; req_b = 32'h0BAD_F00D;
            checkOutput("bp_req_ready", 32'(req_ready), 32'd0);
            checkOutput("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            checkOutput("bp_result", rsp_result, 32'hC000_0000);
            checkOutput("bp_exc_a", exc_a, 32'h3F80_0000);
        end
        @(posedge clk); #1;
        req_valid = 1'b0; rsp_ready = 1'b1;
        @(posedge clk); #1;
        checkOutput("bp_after_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        checkOutput("bp_second_ignored", 32'(busy), 32'd0);

        // reset while the adder is running
        s0 = start_count;
        add_delay = 10; add_value = 32'h40A0_0000;
        applyStimulus(32'h4000_0000, 32'h4040_0000, 1'b0, 3'b000, 31'h0, t);
        @(posedge clk); #3;
        arst_n = 1'b0;
        #1;
        checkOutput("midrst_busy", 32'(busy), 32'd0);
        checkOutput("midrst_req_ready", 32'(req_ready), 32'd1);
        checkOutput("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("midrst_add_start", 32'(add_start), 32'd0);
        checkOutput("midrst_exc_a", exc_a, 32'h0);
        checkOutput("midrst_rsp_result", rsp_result, 32'h0);
        repeat (2) @(posedge clk);
        #3;
        arst_n = 1'b1;
        checkOutput("midrst_starts", 32'(start_count - s0), 32'd1);
        repeat (12) @(posedge clk);
        #1;
        checkOutput("midrst_no_rsp", 32'(rsp_valid), 32'd0);
        runAdd("post_reset_add", 32'h4000_0000, 32'h4000_0000, 4, 32'h4080_0000, 8);

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected $finish");
        $fatal(1, "[TB] watchdog");
    end

endmodule
